// File: rtl/mux8_reg.sv
// mux8_reg -- registered 8:1 datapath source selector.
//
// One of eight XLEN-bit inputs (A..H) is chosen by select and captured into
// the out register on the rising edge of clock. There is exactly one cycle of
// latency, and no combinational path runs from any input to out.
//
// Parameters:
//    XLEN    width of each data input and of out (default 5)
//
// Ports:
//    clock   single clock; all state updates on its rising edge
//    reset   synchronous, active-high; clears out to 0 and overrides everything
//    A..H    data inputs, selected by select = 0..7 respectively
//    select  3-bit input select; every code is legal
//    load    register update enable (only when MUX8REG_LOAD_EN is defined)
//    out     registered copy of the selected input
//
// Build option:
//    MUX8REG_LOAD_EN  When defined, this adds the load port, and out holds its
//                     value on non-reset edges with load=0. When undefined, out
//                     updates on every non-reset edge.

module mux8_reg #(
   parameter int XLEN = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic [XLEN-1:0] C,
   input  logic [XLEN-1:0] D,
   input  logic [XLEN-1:0] E,
   input  logic [XLEN-1:0] F,
   input  logic [XLEN-1:0] G,
   input  logic [XLEN-1:0] H,
   input  logic [2:0]      select,
`ifdef MUX8REG_LOAD_EN
   input  logic            load,
`endif
   output logic [XLEN-1:0] out
);

   logic [XLEN-1:0] sel_data;
   logic            upd_en;

`ifdef MUX8REG_LOAD_EN
   assign upd_en = load;
`else
   assign upd_en = 1'b1;
`endif

   // The decode is full, so the default assignment is never the final value.
   // It is kept only so the block is obviously latch-free.
   always_comb begin
      sel_data = A;
      case (select)
         3'd0: sel_data = A;
         3'd1: sel_data = B;
         3'd2: sel_data = C;
         3'd3: sel_data = D;
         3'd4: sel_data = E;
         3'd5: sel_data = F;
         3'd6: sel_data = G;
         3'd7: sel_data = H;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out <= '0;
      end else if (upd_en) begin
         out <= sel_data;
      end
   end

endmodule

// File: tb/tb_mux8_reg.sv
// tb_mux8_reg -- self-checking bench for mux8_reg (XLEN=5).
// The bench runs directed steps first and then randomized steps. A reference
// model predicts out as the array element that select indexes, captured at
// each rising edge.

module tb_mux8_reg;

   localparam int XLEN = 5;

   logic            clock = 1'b0;
   logic            reset;
   logic [XLEN-1:0] din [8];
   logic [XLEN-1:0] A, B, C, D, E, F, G, H;
   logic [2:0]      select;
   logic            load;
   logic [XLEN-1:0] out;

   int              errors = 0;
   int              checks = 0;
   logic [XLEN-1:0] model_q = '0;

   assign A = din[0];
   assign B = din[1];
   assign C = din[2];
   assign D = din[3];
   assign E = din[4];
   assign F = din[5];
   assign G = din[6];
   assign H = din[7];

   mux8_reg #(.XLEN(XLEN)) dut (
      .clock  (clock),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .C      (C),
      .D      (D),
      .E      (E),
      .F      (F),
      .G      (G),
      .H      (H),
      .select (select),
`ifdef MUX8REG_LOAD_EN
      .load   (load),
`endif
      .out    (out)
   );

   always #5 clock = ~clock;

   // Advance one rising edge. Update the model from the inputs present at that
   // edge, then return 1 time unit later so that checks sample away from the edge.
   task automatic tick();
      logic load_eff;
`ifdef MUX8REG_LOAD_EN
      load_eff = load;
`else
      load_eff = 1'b1;
`endif
      @(posedge clock);
      if (reset)
         model_q = '0;
      else if (load_eff)
         model_q = din[select];
      #1;
   endtask

   task automatic check(input string tag, input logic [XLEN-1:0] exp);
      checks++;
      assert (out === exp)
      else begin
         errors++;
         $error("FAIL %s: out=%h expected=%h", tag, out, exp);
      end
   endtask

   initial begin
      load   = 1'b1;
      reset  = 1'b1;
      select = 3'd7;
      for (int i = 0; i < 8; i++) din[i] = XLEN'($urandom);
      din[7] = 5'h07;

      // Reset wins over select=7 / H=7.
      tick();
      check("reset", 5'h00);

      // Sweep: out follows select with one cycle of lag.
      reset = 1'b0;
      for (int i = 0; i < 8; i++) din[i] = XLEN'(i);
      for (int s = 0; s < 8; s++) begin
         select = 3'(s);
         tick();
         check("sweep", XLEN'(s));
      end

      // Full-width values.
      din[7] = 5'h1F;
      din[0] = 5'h00;
      select = 3'd7;
      tick();
      check("full_width_h", 5'h1F);
      select = 3'd0;
      tick();
      check("full_width_a", 5'h00);

      // Latency: a mid-cycle select change must not reach out before the edge.
      for (int i = 0; i < 8; i++) din[i] = XLEN'(i);
      select = 3'd2;
      tick();
      check("latency_c", 5'h02);
      #2 select = 3'd5;
      #1 check("latency_hold", 5'h02);
      tick();
      check("latency_f", 5'h05);

      // Reset mid-operation.
      select = 3'd6;
      tick();
      check("pre_reset", 5'h06);
      reset = 1'b1;
      tick();
      check("mid_reset", 5'h00);
      reset = 1'b0;
      tick();
      check("post_reset", 5'h06);

`ifdef MUX8REG_LOAD_EN
      select = 3'd3;
      tick();
      check("load_prep", 5'h03);
      load   = 1'b0;
      select = 3'd7;
      tick();
      check("load_hold1", 5'h03);
      tick();
      check("load_hold2", 5'h03);
      load = 1'b1;
      tick();
      check("load_update", 5'h07);
      load  = 1'b0;
      reset = 1'b1;
      tick();
      check("reset_over_load", 5'h00);
      reset = 1'b0;
      load  = 1'b1;
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 8; i++) din[i] = XLEN'($urandom);
         select = 3'($urandom_range(0, 7));
         reset  = ($urandom_range(0, 9) == 0);
`ifdef MUX8REG_LOAD_EN
         load   = ($urandom_range(0, 3) != 0);
`endif
         tick();
         check("random", model_q);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
